// File: rtl/sirv_uartrx_cfg_if.sv
// Pad-side serial input, runtime frame configuration and per-character result bundle
// for the configurable UART receiver.
interface sirv_uartrx_cfg_if #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
);
  logic              io_en;
  logic              io_in;
  logic [DIV_W-1:0]  io_div;
  logic [3:0]        io_nbits;
  logic              io_par_en;
  logic              io_par_odd;
  logic              io_nstop;
  logic              io_out_valid;
  logic [DATA_W-1:0] io_out_bits;
  logic              io_out_perr;
  logic              io_out_ferr;
  logic              io_out_brk;

  modport master (
    output io_en, io_in, io_div, io_nbits, io_par_en, io_par_odd, io_nstop,
    input  io_out_valid, io_out_bits, io_out_perr, io_out_ferr, io_out_brk
  );

  modport slave (
    input  io_en, io_in, io_div, io_nbits, io_par_en, io_par_odd, io_nstop,
    output io_out_valid, io_out_bits, io_out_perr, io_out_ferr, io_out_brk
  );
endinterface

// File: rtl/sirv_uartrx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_W data bits, optional parity, 1/2 stop bits,
// 2**OVS_LOG2 oversampling with 3-sample majority vote; one-cycle valid plus perr/ferr/brk.
module sirv_uartrx_cfg #(
  parameter int DIV_W    = 16,
  parameter int OVS_LOG2 = 4,
  parameter int DATA_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  sirv_uartrx_cfg_if.slave io
);
  localparam int PW = DIV_W - OVS_LOG2;
  localparam int TW = OVS_LOG2 + 1;
  localparam logic [TW-1:0] T_HALF = TW'(1 << (OVS_LOG2 - 1));
  localparam logic [TW-1:0] T_FULL = TW'((1 << OVS_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     presc_q;
  logic [TW-1:0]     timer_q;
  logic [1:0]        deb_q;
  logic [2:0]        hist_q;
  logic [3:0]        idx_q;
  logic [3:0]        nbits_q;
  logic              par_en_q, par_odd_q, nstop_q;
  logic              acc_q, perr_q, ferr_q, seen1_q;
  logic [DATA_W-1:0] shift_q;
  logic              out_valid_q, out_perr_q, out_ferr_q, out_brk_q;
  logic [DATA_W-1:0] out_bits_q;

  logic              busy, tick, expire, voted, start, ferr_d, seen1_d;
  logic [3:0]        nbits_d;
  logic [DATA_W-1:0] shift_d;
  logic              unused_div;

  assign busy    = (state_q != S_IDLE);
  assign tick    = busy && (presc_q == '0);
  assign expire  = tick && (timer_q == '0);
  assign voted   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign start   = (state_q == S_IDLE) && io.io_en && (deb_q == 2'd3) && !io.io_in;
  assign ferr_d  = ferr_q | ~voted;
  assign seen1_d = seen1_q | voted;
  assign nbits_d = (io.io_nbits < 4'd5 || io.io_nbits > 4'(DATA_W)) ? 4'(DATA_W) : io.io_nbits;
  assign shift_d = shift_q | (DATA_W'(voted) << idx_q);
  // Low divisor bits only select the fraction of a bit period below one oversample tick.
  assign unused_div = ^io.io_div[OVS_LOG2-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      timer_q     <= '0;
      deb_q       <= '0;
      hist_q      <= '0;
      idx_q       <= '0;
      nbits_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      nstop_q     <= 1'b0;
      acc_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      seen1_q     <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      out_brk_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (tick) hist_q <= {hist_q[1:0], io.io_in};

      if (start || tick)   presc_q <= io.io_div[DIV_W-1:OVS_LOG2];
      else if (busy)       presc_q <= presc_q - PW'(1);

      if (start)           timer_q <= T_HALF;
      else if (expire)     timer_q <= T_FULL;
      else if (tick)       timer_q <= timer_q - TW'(1);

      if (!io.io_en) begin
        state_q <= S_IDLE;
        deb_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_START;
              deb_q     <= '0;
              nbits_q   <= nbits_d;
              par_en_q  <= io.io_par_en;
              par_odd_q <= io.io_par_odd;
              nstop_q   <= io.io_nstop;
              shift_q   <= '0;
              idx_q     <= '0;
              acc_q     <= 1'b0;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
              seen1_q   <= 1'b0;
            end else if (!io.io_in) begin
              deb_q <= deb_q + 2'd1;
            end else if (deb_q != 2'd0) begin
              deb_q <= deb_q - 2'd1;
            end
          end
          S_START: begin
            if (expire) begin
              state_q <= voted ? S_IDLE : S_DATA;
              idx_q   <= '0;
            end
          end
          S_DATA: begin
            if (expire) begin
              shift_q <= shift_d;
              acc_q   <= acc_q ^ voted;
              seen1_q <= seen1_d;
              idx_q   <= idx_q + 4'd1;
              if (idx_q == nbits_q - 4'd1) state_q <= par_en_q ? S_PARITY : S_STOP1;
            end
          end
          S_PARITY: begin
            if (expire) begin
              perr_q  <= voted ^ acc_q ^ par_odd_q;
              seen1_q <= seen1_d;
              state_q <= S_STOP1;
            end
          end
          S_STOP1, S_STOP2: begin
            if (expire) begin
              seen1_q <= seen1_d;
              ferr_q  <= ferr_d;
              if (state_q == S_STOP1 && nstop_q) begin
                state_q <= S_STOP2;
              end else begin
                // A sampled-low stop means the line may still be low: wait for idle before re-arming.
                out_valid_q <= 1'b1;
                out_bits_q  <= shift_q;
                out_perr_q  <= perr_q;
                out_ferr_q  <= ferr_d;
                out_brk_q   <= ~seen1_d;
                state_q     <= ferr_d ? S_WAIT : S_IDLE;
              end
            end
          end
          S_WAIT: begin
            if (tick && voted) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign io.io_out_valid = out_valid_q;
  assign io.io_out_bits  = out_bits_q;
  assign io.io_out_perr  = out_perr_q;
  assign io.io_out_ferr  = out_ferr_q;
  assign io.io_out_brk   = out_brk_q;
endmodule

// File: tb/tb_sirv_uartrx_cfg.sv
// Bench for sirv_uartrx_cfg: directed frame table, hand-built corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_sirv_uartrx_cfg;
  logic clock;
  logic reset;

  sirv_uartrx_cfg_if #(.DIV_W(16), .DATA_W(8)) ifc ();

  sirv_uartrx_cfg #(.DIV_W(16), .OVS_LOG2(4), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .io    (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int data; int ncfg; int nline; int pen; int podd; int pbit; int nstop; int s1; int s2;
    int eb; int ep; int ef; int ek;
  } vec_t;

  typedef struct { int bits; int perr; int ferr; int brk; int cyc; } rx_t;

  rx_t  rxq[$];
  int   cyc;
  int   stop_cyc;
  int   n_vec;
  int   n_bad;
  vec_t vt[14];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (ifc.io_out_valid === 1'b1)
      rxq.push_back('{int'(ifc.io_out_bits), int'(ifc.io_out_perr), int'(ifc.io_out_ferr),
                      int'(ifc.io_out_brk), cyc});
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input int v, input int n);
    ifc.io_in = v[0];
    repeat (n) @(negedge clock);
  endtask

  task automatic set_cfg(input int ncfg, input int pen, input int podd, input int nstop, input int div);
    ifc.io_nbits   = 4'(ncfg);
    ifc.io_par_en  = pen[0];
    ifc.io_par_odd = podd[0];
    ifc.io_nstop   = nstop[0];
    ifc.io_div     = 16'(div);
  endtask

  // Full frame on the line followed by two idle bit times; optionally scrambles config mid-frame.
  task automatic send_frame(input int data, input int nline, input int pen, input int pbit,
                            input int nstop, input int s1, input int s2, input int bc, input int scr);
    drive_bit(0, bc);
    if (scr != 0) begin
      ifc.io_nbits   = 4'($urandom_range(0, 15));
      ifc.io_par_en  = 1'($urandom_range(0, 1));
      ifc.io_par_odd = 1'($urandom_range(0, 1));
      ifc.io_nstop   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nline; i++) drive_bit((data >> i) & 1, bc);
    if (pen != 0) drive_bit(pbit, bc);
    stop_cyc = cyc;
    drive_bit(s1, bc);
    if (nstop != 0) begin
      stop_cyc = cyc;
      drive_bit(s2, bc);
    end
    drive_bit(1, 2 * bc);
  endtask

  task automatic check_frame(input string nm, input int eb, input int ep, input int ef,
                             input int ek, input int bc);
    rx_t r;
    int  lat;
    chk({nm, " count"}, rxq.size(), 1);
    if (rxq.size() > 0) begin
      r = rxq.pop_front();
      chk({nm, " bits"}, r.bits, eb);
      chk({nm, " perr"}, r.perr, ep);
      chk({nm, " ferr"}, r.ferr, ef);
      chk({nm, " brk"},  r.brk,  ek);
      lat = r.cyc - stop_cyc;
      chk($sformatf("%s latency=%0d within", nm, lat), int'(lat <= bc + bc / 2), 1);
    end
    rxq.delete();
  endtask

  initial begin
    int ncfg, nb, data, pen, podd, pbit, nstop, s1, s2, div, bc, ones, ep, ef, ek;
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    stop_cyc = 0;
    reset = 1'b1;
    ifc.io_en = 1'b1;
    ifc.io_in = 1'b1;
    set_cfg(8, 0, 0, 0, 16);

    //        data   ncfg nline pen podd pbit nstop s1 s2   eb    ep ef ek
    vt[0]  = '{'h0A5, 8,   8,   0,  0,   0,   0,   1, 1,   'hA5, 0, 0, 0};
    vt[1]  = '{'h041, 7,   7,   1,  0,   0,   0,   1, 1,   'h41, 0, 0, 0};
    vt[2]  = '{'h041, 7,   7,   1,  0,   1,   0,   1, 1,   'h41, 1, 0, 0};
    vt[3]  = '{'h03C, 8,   8,   0,  0,   0,   1,   1, 0,   'h3C, 0, 1, 0};
    vt[4]  = '{'h015, 5,   5,   1,  1,   0,   0,   1, 1,   'h15, 0, 0, 0};
    vt[5]  = '{'h0FF, 3,   8,   0,  0,   0,   0,   1, 1,   'hFF, 0, 0, 0};
    vt[6]  = '{'h0FF, 5,   5,   0,  0,   0,   0,   1, 1,   'h1F, 0, 0, 0};
    vt[7]  = '{'h081, 8,   8,   0,  0,   0,   0,   0, 1,   'h81, 0, 1, 0};
    vt[8]  = '{'h000, 8,   8,   0,  0,   0,   0,   0, 1,   'h00, 0, 1, 1};
    vt[9]  = '{'h05A, 9,   8,   0,  0,   0,   0,   1, 1,   'h5A, 0, 0, 0};
    vt[10] = '{'h000, 6,   6,   1,  1,   1,   0,   1, 1,   'h00, 0, 0, 0};
    vt[11] = '{'h02A, 6,   6,   1,  1,   1,   0,   1, 1,   'h2A, 1, 0, 0};
    vt[12] = '{'h000, 8,   8,   1,  0,   0,   1,   0, 0,   'h00, 0, 1, 1};
    vt[13] = '{'h000, 8,   8,   1,  0,   1,   0,   0, 1,   'h00, 1, 1, 0};

    repeat (3) @(negedge clock);
    chk("reset valid", int'(ifc.io_out_valid), 0);
    chk("reset bits",  int'(ifc.io_out_bits),  0);
    chk("reset perr",  int'(ifc.io_out_perr),  0);
    chk("reset ferr",  int'(ifc.io_out_ferr),  0);
    chk("reset brk",   int'(ifc.io_out_brk),   0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int k = 0; k < 14; k++) begin
      set_cfg(vt[k].ncfg, vt[k].pen, vt[k].podd, vt[k].nstop, 16);
      send_frame(vt[k].data, vt[k].nline, vt[k].pen, vt[k].pbit, vt[k].nstop,
                 vt[k].s1, vt[k].s2, 32, 0);
      check_frame($sformatf("vec%0d", k), vt[k].eb, vt[k].ep, vt[k].ef, vt[k].ek, 32);
    end

    // Short low glitches in idle must not produce a character.
    set_cfg(8, 0, 0, 0, 16);
    drive_bit(0, 2);
    drive_bit(1, 96);
    chk("glitch2 no valid", rxq.size(), 0);
    drive_bit(0, 10);
    drive_bit(1, 96);
    chk("false start no valid", rxq.size(), 0);
    rxq.delete();

    // Held break: exactly one character, then recovery on a fresh start bit.
    stop_cyc = cyc + 9 * 32;
    drive_bit(0, 40 * 32);
    drive_bit(1, 3 * 32);
    check_frame("break", 0, 0, 1, 1, 32 * 32);
    send_frame('h96, 8, 0, 0, 0, 1, 1, 32, 0);
    check_frame("after break", 'h96, 0, 0, 0, 32);

    // Enable drop while receiving data bits discards the frame.
    fork
      send_frame('hF0, 8, 0, 0, 0, 1, 1, 32, 0);
      begin
        repeat (6 * 32 + 16) @(negedge clock);
        ifc.io_en = 1'b0;
        @(negedge clock);
        ifc.io_en = 1'b1;
      end
    join
    chk("en drop no valid", rxq.size(), 0);
    rxq.delete();
    send_frame('h5A, 8, 0, 0, 0, 1, 1, 32, 0);
    check_frame("after en drop", 'h5A, 0, 0, 0, 32);

    // Randomized frames against the frame-level model; config is scrambled after each start bit.
    for (int k = 0; k < 24; k++) begin
      ncfg  = $urandom_range(0, 15);
      nb    = (ncfg < 5 || ncfg > 8) ? 8 : ncfg;
      data  = $urandom_range(0, 255) & ((1 << nb) - 1);
      if ($urandom_range(0, 5) == 0) data = 0;
      pen   = $urandom_range(0, 1);
      podd  = $urandom_range(0, 1);
      pbit  = $urandom_range(0, 1);
      nstop = $urandom_range(0, 1);
      s1    = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s2    = ($urandom_range(0, 3) != 0) ? 1 : 0;
      div   = $urandom_range(16, 63);
      bc    = 16 * ((div >> 4) + 1);
      ones  = $countones(data);
      ep    = (pen != 0 && ((ones + pbit) % 2) != podd) ? 1 : 0;
      ef    = (s1 == 0 || (nstop != 0 && s2 == 0)) ? 1 : 0;
      ek    = (data == 0 && !(pen != 0 && pbit != 0) && s1 == 0 && !(nstop != 0 && s2 != 0)) ? 1 : 0;
      set_cfg(ncfg, pen, podd, nstop, div);
      send_frame(data, nb, pen, pbit, nstop, s1, s2, bc, 1);
      check_frame($sformatf("rnd%0d", k), data, ep, ef, ek, bc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sirv_uartrx_cfg.md
Name: sirv_uartrx_cfg

Overview:
Parametrised, runtime-configurable UART receiver for the peripheral subsystem. It succeeds the fixed 8N1 receiver with programmable data bits (5..DATA_W), optional even/odd parity, 1 or 2 stop bits, and a generic oversampling ratio. It reports parity error, framing error and line-break status alongside each character. It sits between the pad input and the UART RX FIFO and keeps the same single-cycle valid/bits output style.

Parameters:
DIV_W, 16, width of io_div.
OVS_LOG2, 4, log2 of oversample ticks per bit (OVS = 2**OVS_LOG2); legal range 2..5.
DATA_W, 8, maximum data bits per character; legal range 5..9.

Ports:
clock  input  1  clock.
reset  input  1  reset, asynchronous, active-high.
io_en  input  1  receiver enable; low aborts any frame and holds idle.
io_in  input  1  serial line; idle high.
io_div  input  DIV_W  bit-period divisor in clocks; tick period = io_div[DIV_W-1:OVS_LOG2] + 1 clocks.
io_nbits  input  4  data bits per character; values <5 or >DATA_W are treated as DATA_W.
io_par_en  input  1  parity bit present.
io_par_odd  input  1  1 = odd parity, 0 = even parity.
io_nstop  input  1  0 = one stop bit, 1 = two stop bits.
io_out_valid  output  1  one-cycle pulse: character complete.
io_out_bits  output  DATA_W  received data, LSB first on line, right-aligned, unused MSBs zero.
io_out_perr  output  1  parity mismatch, qualified by io_out_valid.
io_out_ferr  output  1  any stop bit sampled 0, qualified by io_out_valid.
io_out_brk  output  1  break: all data, parity and stop samples 0; qualified by io_out_valid; implies ferr.

Behaviour:
- Reset: state IDLE; prescaler, timer, debounce, sample history, bit index, shifter all 0. Outputs: valid 0, bits 0, perr/ferr/brk 0.
- Prescaler: counts down only while busy (state != IDLE). tick = (prescaler==0) & busy. Reload with io_div[DIV_W-1:OVS_LOG2] on start or tick.
- Sampler: on each tick, shift io_in into a 3-bit history. voted = majority of the 3 history bits.
- Timer: width OVS_LOG2+1. On start, load OVS/2. On tick, decrement. expire = (timer==0) & tick; on expire, reload OVS-1.
- IDLE debounce (2-bit): io_in==0 increments; io_in==1 decrements if nonzero. When debounce==3 and io_in==0, issue start: go to START.
- On start, latch nbits/par_en/par_odd/nstop. Config changes mid-frame have no effect. Clear shifter, index and parity accumulator.
- START: on expire, voted==1 -> IDLE (false start, no valid); else -> DATA, index=0.
- DATA: on expire, shifter[index] = voted, parity accumulator ^= voted, index++. When index reaches nbits-1 -> PARITY if par_en, else STOP1.
- PARITY: on expire, perr = voted ^ acc ^ par_odd. Even parity: total ones including the parity bit is even. -> STOP1.
- STOP1: on expire, ferr |= ~voted. If nstop -> STOP2, else finish.
- STOP2: on expire, ferr |= ~voted; finish.
- Finish: next cycle io_out_valid=1 for exactly one cycle, with bits/perr/ferr/brk held stable until the next finish.
- After finish: ferr=0 -> IDLE. ferr=1 -> WAIT_HIGH, staying busy and ticking, until voted==1 on a tick, then IDLE. A held break yields exactly one valid.
- Entering IDLE always clears debounce to 0.
- io_en low: next state IDLE, debounce 0, no valid produced, any partial frame discarded. io_out_bits/flags retain their last values.
- Flags are combinational from registered state only; no combinational path from io_in to outputs.

Test Plan:
- io_div=16, nbits=8, no parity, 1 stop; send 0xA5 at 32 clk/bit -> one valid, bits=0xA5, perr=ferr=brk=0, valid within one bit period after the stop-bit midpoint.
- nbits=7, par_en=1, par_odd=0; send 0x41 with parity 0 -> bits=0x41, perr=0. Repeat with the parity bit flipped -> perr=1, bits=0x41.
- nbits=8, nstop=1; send 0x3C, first stop bit 1, second stop bit 0 -> valid, bits=0x3C, ferr=1, brk=0, then return to IDLE once the line is high.
- Hold io_in low for 40 bit times -> exactly one valid with bits=0x00, ferr=1, brk=1. No further valid until the line is high and a new start bit arrives.
- 2-clock low glitch in IDLE -> no START entered. Low pulse of 0.3 bit then high -> START aborts to IDLE, no valid.
- Drop io_en mid-DATA for 1 cycle, then resend 0x5A -> first frame lost with no valid, second frame bits=0x5A; debounce restarts from 0.
